ysyx_23060191_ifu_fetch: RTL and testbench
==========================================

Name: ysyx_23060191_ifu_fetch

Overview:
Instruction fetch stage sitting directly downstream of the PC unit.
- Accepts a fetch PC via valid/ready.
- Issues one single-beat AXI4-Lite read (AR/R channels only) to instruction memory.
- Holds the returned instruction with its PC until the decode stage accepts it.
- Supports one outstanding fetch, flush/redirect that discards in-flight data, misaligned-PC and bus-error reporting, and a completed-fetch counter.

Parameters:
CPU_WIDTH, 32, data/address width
CNT_WIDTH, 32, width of the completed-fetch counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
i_pc  in  CPU_WIDTH  fetch address from PC unit
i_pc_valid  in  1  i_pc is valid
o_pc_ready  out  1  fetch stage can accept a PC
o_araddr  out  CPU_WIDTH  AXI read address
o_arvalid  out  1  AXI read address valid
i_arready  in  1  AXI read address ready
i_rdata  in  CPU_WIDTH  AXI read data
i_rresp  in  2  AXI read response (0 = OKAY)
i_rvalid  in  1  AXI read data valid
o_rready  out  1  AXI read data ready
o_inst  out  CPU_WIDTH  fetched instruction
o_inst_pc  out  CPU_WIDTH  PC of o_inst
o_inst_valid  out  1  o_inst/o_inst_pc/o_fetch_err valid
i_inst_ready  in  1  decode accepts instruction
o_fetch_err  out  1  instruction access fault or misaligned fetch
i_flush  in  1  redirect: discard current fetch
o_fetch_cnt  out  CNT_WIDTH  count of instructions delivered to decode

Behaviour:
- Reset (async, rst=1): state IDLE.
  - All outputs 0: o_pc_ready, o_arvalid, o_rready, o_inst_valid, o_fetch_err, o_araddr, o_inst, o_inst_pc, o_fetch_cnt.
  - Internal drop flag cleared.
  - Reset mid-transaction abandons it; the memory side is reset by the same rst.
- States: IDLE, AR, R, HOLD, DRAIN.
- IDLE:
  - o_pc_ready = ~i_flush.
  - On i_pc_valid & o_pc_ready: latch i_pc into the address register.
  - If i_pc[1:0] != 0: go HOLD with o_fetch_err=1, o_inst=0, no bus request.
  - Otherwise go AR.
- AR:
  - o_arvalid=1; o_araddr is the latched PC, held stable until handshake.
  - On i_arready: go R.
  - i_flush here: arvalid is never withdrawn (AXI rule). On handshake, go DRAIN instead of R.
- R:
  - o_rready=1.
  - On i_rvalid: capture o_inst=i_rdata, o_inst_pc=latched PC, o_fetch_err=(i_rresp!=0). Go HOLD.
  - i_flush with no i_rvalid: go DRAIN.
  - i_flush in the same cycle as i_rvalid: response discarded, go IDLE.
- DRAIN:
  - o_rready=1.
  - On i_rvalid: discard data, go IDLE.
  - Further i_flush has no additional effect.
- HOLD:
  - o_inst_valid=1; outputs stable while stalled.
  - On i_inst_ready: o_fetch_cnt += 1 (wraps modulo 2^CNT_WIDTH), go IDLE.
  - i_flush: go IDLE, no count, o_inst_valid drops next cycle.
  - i_flush and i_inst_ready together: flush wins, no count.
- Latency, zero-wait memory:
  - Accept PC at cycle 0; arvalid at cycle 1.
  - rvalid at cycle 2 (earliest); o_inst_valid at cycle 3.
  - Next PC accepted at cycle 4 (o_pc_ready asserted cycle 4).
  - No overlapping fetches.
- o_arvalid, o_rready, o_inst_valid, o_pc_ready are decoded from registered state. o_pc_ready additionally gated by i_flush.
- Misaligned error path: o_inst_pc = faulting PC; counted like a normal delivery.

Test Plan:
- Reset mid-AR (rst asserted with arvalid=1) -> all outputs 0 immediately, state IDLE, next i_pc_valid accepted.
- PC 0x80000000, memory returns 0x00000413 OKAY, zero wait, i_inst_ready=1 -> arvalid cycle 1 with araddr 0x80000000; o_inst_valid cycle 3 with o_inst=0x00000413, o_inst_pc=0x80000000, err=0; o_fetch_cnt=1.
- arready delayed 3 cycles, rvalid delayed 2, i_inst_ready low 4 cycles -> araddr/arvalid stable until handshake; o_inst stable while stalled; single count on acceptance.
- i_flush in R before rvalid, then rvalid with 0xDEADBEEF -> rvalid consumed in DRAIN, o_inst_valid never asserted, count unchanged, next PC 0x80000100 fetches correctly.
- PC 0x80000002 -> no arvalid; o_inst_valid with o_fetch_err=1, o_inst_pc=0x80000002. Separately, rresp=2'b10 on an aligned fetch -> o_fetch_err=1.
- CNT_WIDTH=4, 16 deliveries -> o_fetch_cnt wraps 15->0.

Source files
------------

// File: rtl/ysyx_23060191_ifu_fetch_if.sv
// Fetch-stage bundle: the PC-unit handshake, the AXI4-Lite AR/R channels and the decode handshake.
// Every handshake is valid/ready: a transfer occurs on a rising clk edge where both are 1, and a
// source holding valid high keeps its payload stable until that transfer (arvalid is never withdrawn).
interface ysyx_23060191_ifu_fetch_if #(
  parameter int CPU_WIDTH = 32,
  parameter int CNT_WIDTH = 32
);
  logic [CPU_WIDTH-1:0] i_pc;
  logic                 i_pc_valid;
  logic                 o_pc_ready;
  logic [CPU_WIDTH-1:0] o_araddr;
  logic                 o_arvalid;
  logic                 i_arready;
  logic [CPU_WIDTH-1:0] i_rdata;
  logic [1:0]           i_rresp;
  logic                 i_rvalid;
  logic                 o_rready;
  logic [CPU_WIDTH-1:0] o_inst;
  logic [CPU_WIDTH-1:0] o_inst_pc;
  logic                 o_inst_valid;
  logic                 i_inst_ready;
  logic                 o_fetch_err;
  logic                 i_flush;
  logic [CNT_WIDTH-1:0] o_fetch_cnt;

  // master: the fetch stage itself
  modport master (
    input  i_pc, i_pc_valid, i_arready, i_rdata, i_rresp, i_rvalid, i_inst_ready, i_flush,
    output o_pc_ready, o_araddr, o_arvalid, o_rready, o_inst, o_inst_pc, o_inst_valid,
           o_fetch_err, o_fetch_cnt
  );

  // slave: PC unit, instruction memory and decode seen together
  modport slave (
    output i_pc, i_pc_valid, i_arready, i_rdata, i_rresp, i_rvalid, i_inst_ready, i_flush,
    input  o_pc_ready, o_araddr, o_arvalid, o_rready, o_inst, o_inst_pc, o_inst_valid,
           o_fetch_err, o_fetch_cnt
  );
endinterface

// File: rtl/ysyx_23060191_ifu_fetch.sv
// Instruction fetch: one outstanding single-beat AXI4-Lite read per PC, result held until decode
// takes it. Flush discards in-flight data; misaligned PCs and error responses are reported.
module ysyx_23060191_ifu_fetch #(
  parameter int CPU_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_23060191_ifu_fetch_if.master  bus,
  output logic [2:0]                 o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AR    = 3'd1,
    R     = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CPU_WIDTH-1:0] addr_q;
  logic [CPU_WIDTH-1:0] inst_q;
  logic [CPU_WIDTH-1:0] inst_pc_q;
  logic                 err_q;
  logic                 drop_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic pc_fire;
  logic misaligned;
  logic ar_fire;
  logic r_fire;
  logic deliver;

  always_comb begin
    pc_fire    = (state_q == IDLE) && bus.i_pc_valid && !bus.i_flush;
    misaligned = (bus.i_pc[1:0] != 2'b00);
    ar_fire    = (state_q == AR) && bus.i_arready;
    r_fire     = (state_q == R) && bus.i_rvalid && !bus.i_flush;
    deliver    = (state_q == HOLD) && bus.i_inst_ready && !bus.i_flush;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pc_fire) state_d = misaligned ? HOLD : AR;
      end
      AR: begin
        // A flush seen at any point during AR turns the response into one to discard.
        if (bus.i_arready) state_d = (drop_q || bus.i_flush) ? DRAIN : R;
      end
      R: begin
        if (bus.i_rvalid)     state_d = bus.i_flush ? IDLE : HOLD;
        else if (bus.i_flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.i_rvalid) state_d = IDLE;
      end
      HOLD: begin
        if (bus.i_flush || bus.i_inst_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (pc_fire) begin
        addr_q <= bus.i_pc;
        if (misaligned) begin
          inst_q    <= '0;
          inst_pc_q <= bus.i_pc;
          err_q     <= 1'b1;
        end
      end
      if (state_q == AR) begin
        if (ar_fire)          drop_q <= 1'b0;
        else if (bus.i_flush) drop_q <= 1'b1;
      end
      if (r_fire) begin
        inst_q    <= bus.i_rdata;
        inst_pc_q <= addr_q;
        err_q     <= (bus.i_rresp != 2'b00);
      end
      if (deliver) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Handshake outputs decode straight from the state register; pc_ready also drops under flush/reset.
  assign bus.o_pc_ready   = (state_q == IDLE) && !bus.i_flush && !rst;
  assign bus.o_arvalid    = (state_q == AR);
  assign bus.o_rready     = (state_q == R) || (state_q == DRAIN);
  assign bus.o_inst_valid = (state_q == HOLD);
  assign bus.o_araddr     = addr_q;
  assign bus.o_inst       = inst_q;
  assign bus.o_inst_pc    = inst_pc_q;
  assign bus.o_fetch_err  = err_q;
  assign bus.o_fetch_cnt  = cnt_q;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_ysyx_23060191_ifu_fetch.sv
// Bench for ysyx_23060191_ifu_fetch: directed latency/stall/flush/error cases plus random traffic,
// checked every cycle against a transaction-level model of one outstanding fetch.
module tb_ysyx_23060191_ifu_fetch;

  localparam int W  = 32;
  localparam int CW = 4;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  ysyx_23060191_ifu_fetch_if #(.CPU_WIDTH(W), .CNT_WIDTH(CW)) bus ();

  ysyx_23060191_ifu_fetch #(.CPU_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int ar_pct = 100;
  int r_pct  = 100;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: two pinned words, a hash elsewhere; addresses with [5:2]==F answer SLVERR.
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    if (a == 32'h8000_0040) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [1:0] resp_of(input logic [W-1:0] a);
    return (a[5:2] == 4'hF) ? 2'b10 : 2'b00;
  endfunction

  // ---------------- memory responder ----------------
  logic         r_pend;
  logic [W-1:0] r_addr;
  initial begin
    r_pend = 1'b0;
    r_addr = '0;
    bus.i_arready = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_rdata   = '0;
    bus.i_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_pend = 1'b0;
      end else begin
        if (bus.i_rvalid && bus.o_rready) r_pend = 1'b0;
        if (bus.o_arvalid && bus.i_arready) begin
          r_pend = 1'b1;
          r_addr = bus.o_araddr;
        end
      end
      @(posedge clk);
      #1;
      bus.i_arready = ($urandom_range(0, 99) < ar_pct);
      bus.i_rvalid  = r_pend && (bus.i_rvalid || ($urandom_range(0, 99) < r_pct));
      bus.i_rdata   = r_pend ? mem_word(r_addr) : '0;
      bus.i_rresp   = r_pend ? resp_of(r_addr) : 2'b00;
    end
  end

  // ---------------- reference model + per-cycle scoreboard ----------------
  // m_ar: read address owed; m_r: read data owed; m_live: owed data still wanted;
  // exp_q: the one instruction decode must currently be offered {err, pc, inst}.
  logic          m_ar, m_r, m_live;
  logic [W-1:0]  m_pc;
  logic [CW-1:0] m_cnt;
  logic [2*W:0]  exp_q[$];
  logic [CW-1:0] prev_cnt;
  logic          wrap_seen;

  initial begin
    m_ar = 0; m_r = 0; m_live = 0; m_pc = '0; m_cnt = '0;
    prev_cnt = '0; wrap_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ar = 0; m_r = 0; m_live = 0; m_cnt = '0;
        exp_q.delete();
      end
      chk("pc_ready", 32'(bus.o_pc_ready),
          32'(!rst && exp_q.size() == 0 && !m_ar && !m_r && !bus.i_flush));
      chk("arvalid", 32'(bus.o_arvalid), 32'(m_ar));
      chk("rready", 32'(bus.o_rready), 32'(m_r));
      chk("inst_valid", 32'(bus.o_inst_valid), 32'(exp_q.size() != 0));
      chk("fetch_cnt", 32'(bus.o_fetch_cnt), 32'(m_cnt));
      if (m_ar) chk("araddr", bus.o_araddr, m_pc);
      if (exp_q.size() != 0) begin
        chk("inst", bus.o_inst, exp_q[0][W-1:0]);
        chk("inst_pc", bus.o_inst_pc, exp_q[0][2*W-1:W]);
        chk("fetch_err", 32'(bus.o_fetch_err), 32'(exp_q[0][2*W]));
      end
      if (!rst && prev_cnt == 4'hF && bus.o_fetch_cnt == 4'h0) wrap_seen = 1'b1;
      prev_cnt = bus.o_fetch_cnt;

      if (!rst) begin
        if (exp_q.size() != 0) begin
          if (bus.i_flush) void'(exp_q.pop_front());
          else if (bus.i_inst_ready) begin
            void'(exp_q.pop_front());
            m_cnt = m_cnt + 1'b1;
          end
        end else if (m_r) begin
          if (bus.i_rvalid) begin
            m_r = 0;
            if (m_live && !bus.i_flush)
              exp_q.push_back({(resp_of(m_pc) != 2'b00), m_pc, mem_word(m_pc)});
            m_live = 0;
          end else if (bus.i_flush) m_live = 0;
        end else if (m_ar) begin
          if (bus.i_flush) m_live = 0;
          if (bus.i_arready) begin
            m_ar = 0;
            m_r  = 1;
          end
        end else if (bus.i_pc_valid && !bus.i_flush) begin
          m_pc = bus.i_pc;
          if (bus.i_pc[1:0] != 2'b00) exp_q.push_back({1'b1, bus.i_pc, 32'h0});
          else begin
            m_ar   = 1;
            m_live = 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.o_arvalid;
      1:       return bus.o_rready;
      2:       return bus.o_inst_valid;
      default: return bus.o_pc_ready;
    endcase
  endfunction

  // Returns at a negedge where the selected output is high, or reports a timeout.
  task automatic wait_sig(input string name, input int sel);
    int t = 0;
    @(negedge clk);
    while (!sig(sel) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: got 0 expected 1 within 200 cycles", name);
    end
  endtask

  // Presents a PC until it is taken; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] pc);
    @(posedge clk);
    #1;
    bus.i_pc_valid = 1'b1;
    bus.i_pc       = pc;
    wait_sig("pc_accept", 3);
    @(posedge clk);
    #1;
    bus.i_pc_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [CW-1:0] cnt0;
  initial begin
    rst = 1'b1;
    bus.i_pc = '0; bus.i_pc_valid = 1'b0; bus.i_inst_ready = 1'b0; bus.i_flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc_ready", 32'(bus.o_pc_ready), 0);
    chk("rst_araddr", bus.o_araddr, 0);
    chk("rst_inst", bus.o_inst, 0);
    chk("rst_inst_pc", bus.o_inst_pc, 0);
    chk("rst_err", 32'(bus.o_fetch_err), 0);
    @(posedge clk); #1; rst = 1'b0;

    // reset while a read address is waiting for arready
    @(negedge clk); ar_pct = 0;
    issue(32'h8000_0020);
    @(negedge clk);
    chk("midar_arvalid", 32'(bus.o_arvalid), 1);
    @(posedge clk); #1; rst = 1'b1; #1;
    chk("midar_rst_arvalid", 32'(bus.o_arvalid), 0);
    chk("midar_rst_araddr", bus.o_araddr, 0);
    chk("midar_rst_pc_ready", 32'(bus.o_pc_ready), 0);
    chk("midar_rst_inst_valid", 32'(bus.o_inst_valid), 0);
    @(negedge clk); ar_pct = 100; r_pct = 100;
    @(posedge clk); #1; rst = 1'b0;

    // zero-wait latency: accept at cycle 0 .. next PC ready at cycle 4
    @(posedge clk); #1;
    bus.i_pc_valid = 1'b1; bus.i_pc = 32'h8000_0000; bus.i_inst_ready = 1'b1;
    @(negedge clk); chk("lat_c0_pc_ready", 32'(bus.o_pc_ready), 1);
    @(posedge clk); #1; bus.i_pc_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_arvalid", 32'(bus.o_arvalid), 1);
    chk("lat_c1_araddr", bus.o_araddr, 32'h8000_0000);
    @(negedge clk);
    chk("lat_c2_rready", 32'(bus.o_rready), 1);
    chk("lat_c2_inst_valid", 32'(bus.o_inst_valid), 0);
    @(negedge clk);
    chk("lat_c3_inst_valid", 32'(bus.o_inst_valid), 1);
    chk("lat_c3_inst", bus.o_inst, 32'h0000_0413);
    chk("lat_c3_inst_pc", bus.o_inst_pc, 32'h8000_0000);
    chk("lat_c3_err", 32'(bus.o_fetch_err), 0);
    @(negedge clk);
    chk("lat_c4_pc_ready", 32'(bus.o_pc_ready), 1);
    chk("lat_c4_cnt", 32'(bus.o_fetch_cnt), 1);

    // slow arready, slow rvalid, decode stalled four cycles
    ar_pct = 0; r_pct = 0;
    @(posedge clk); #1; bus.i_inst_ready = 1'b0;
    issue(32'h8000_0080);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("slow_arvalid", 32'(bus.o_arvalid), 1);
      chk("slow_araddr", bus.o_araddr, 32'h8000_0080);
    end
    ar_pct = 100;
    wait_sig("slow_r", 1);
    repeat (2) begin
      @(negedge clk);
      chk("slow_r_wait", 32'(bus.o_inst_valid), 0);
    end
    r_pct = 100;
    wait_sig("slow_hold", 2);
    cnt0 = bus.o_fetch_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_inst", bus.o_inst, mem_word(32'h8000_0080));
      chk("stall_cnt", 32'(bus.o_fetch_cnt), 32'(cnt0));
    end
    @(posedge clk); #1; bus.i_inst_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("stall_release_cnt", 32'(bus.o_fetch_cnt), 32'(cnt0 + 1'b1));

    // flush while waiting for read data; the late 0xDEADBEEF must be drained
    r_pct = 0;
    cnt0 = bus.o_fetch_cnt;
    issue(32'h8000_0040);
    wait_sig("flush_r", 1);
    @(posedge clk); #1; bus.i_flush = 1'b1;
    @(posedge clk); #1; bus.i_flush = 1'b0;
    @(negedge clk); r_pct = 100;
    wait_sig("flush_drain", 3);
    chk("flush_cnt", 32'(bus.o_fetch_cnt), 32'(cnt0));
    issue(32'h8000_0100);
    @(negedge clk);
    chk("post_flush_araddr", bus.o_araddr, 32'h8000_0100);
    wait_sig("post_flush_hold", 2);
    chk("post_flush_inst", bus.o_inst, mem_word(32'h8000_0100));
    chk("post_flush_pc", bus.o_inst_pc, 32'h8000_0100);

    // misaligned PC never reaches the bus
    issue(32'h8000_0002);
    @(negedge clk);
    chk("mis_inst_valid", 32'(bus.o_inst_valid), 1);
    chk("mis_arvalid", 32'(bus.o_arvalid), 0);
    chk("mis_err", 32'(bus.o_fetch_err), 1);
    chk("mis_inst_pc", bus.o_inst_pc, 32'h8000_0002);
    chk("mis_inst", bus.o_inst, 0);

    // SLVERR response on an aligned fetch
    issue(32'h8000_003C);
    wait_sig("slverr_hold", 2);
    chk("slverr_err", 32'(bus.o_fetch_err), 1);
    chk("slverr_pc", bus.o_inst_pc, 32'h8000_003C);

    // random traffic
    @(negedge clk); ar_pct = 60; r_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.i_pc_valid   = ($urandom_range(0, 99) < 70);
      bus.i_pc         = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2)
                         | (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      bus.i_flush      = ($urandom_range(0, 99) < 5);
      bus.i_inst_ready = ($urandom_range(0, 99) < 60);
    end
    @(posedge clk); #1;
    bus.i_pc_valid = 1'b0; bus.i_flush = 1'b0; bus.i_inst_ready = 1'b1;
    @(negedge clk); ar_pct = 100; r_pct = 100;
    repeat (20) @(negedge clk);
    chk("cnt_wrap_seen", 32'(wrap_seen), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
